// File: rtl/base_rrmux_pkg.sv
// Shared types for the packet-aware round-robin stream arbiter.
package base_rrmux_pkg;

    typedef enum logic {
        LOCK_IDLE,
        LOCK_HELD
    } lock_state_e;

endpackage

// File: rtl/base_mux.sv
// One-hot AND-OR data mux: q is the slice of d picked by the single set bit of sel.
module base_mux #(
    parameter int width = 1,
    parameter int ways  = 2
) (
    input  logic [ways-1:0]       sel,
    input  logic [width*ways-1:0] d,
    output logic [width-1:0]      q
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        q = '0;
        for (int j = 0; j < ways; j++) begin
            if (sel[j]) begin
                q = q | d[j*width +: width];
            end
        end
    end

endmodule

// File: rtl/base_rrarb.sv
// Rotate-priority encoder: one-hot grant to the first requester at or after ptr, wrapping.
module base_rrarb #(
    parameter int ways = 2,
    parameter int pw   = (ways > 1) ? $clog2(ways) : 1
) (
    input  logic [ways-1:0] req,
    input  logic [pw-1:0]   ptr,
    output logic [ways-1:0] grant
);

    logic [pw:0] idx;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < ways; i++) begin
            // One extra bit so ptr+i cannot overflow before the wrap for non-power-of-two ways.
            idx = {1'b0, ptr} + (pw+1)'(i);
            if (idx >= (pw+1)'(ways)) begin
                idx = idx - (pw+1)'(ways);
            end
            if (!found && req[idx[pw-1:0]]) begin
                grant[idx[pw-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/base_rrmux.sv
// Packet-aware round-robin N-to-1 stream arbiter with a one-deep registered output stage.
module base_rrmux
    import base_rrmux_pkg::*;
#(
    parameter int width = 1,
    parameter int ways  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ways-1:0]       i_v,
    output logic [ways-1:0]       i_r,
    input  logic [ways-1:0]       i_e,
    input  logic [width*ways-1:0] i_d,
    output logic                  o_v,
    input  logic                  o_r,
    output logic                  o_e,
    output logic [width-1:0]      o_d,
    output logic [ways-1:0]       o_sel
);

    localparam int pw = (ways > 1) ? $clog2(ways) : 1;

    lock_state_e     state_q, state_d;
    logic [pw-1:0]   lock_way_q, lock_way_d;
    logic [pw-1:0]   ptr_q;
    logic [pw-1:0]   g_idx;
    logic [ways-1:0] arb_grant, lock_mask, grant;
    logic [width-1:0] sel_d;
    logic            en, accept, sel_e;

    // Reset also blocks acceptance so no beat is consumed upstream while it is discarded here.
    assign en = (~o_v | o_r) & ~reset;

    base_rrarb #(.ways(ways), .pw(pw)) u_arb (
        .req   (i_v),
        .ptr   (ptr_q),
        .grant (arb_grant)
    );

    always_comb begin
        lock_mask             = '0;
        lock_mask[lock_way_q] = 1'b1;
    end

    always_comb begin
        if (ways == 1) begin
            grant = i_v;
        end else if (state_q == LOCK_HELD) begin
            grant = i_v & lock_mask;
        end else begin
            grant = arb_grant;
        end
    end

    assign i_r    = grant & {ways{en}};
    assign accept = |i_r;
    assign sel_e  = |(grant & i_e);

    always_comb begin
        g_idx = '0;
        for (int j = 0; j < ways; j++) begin
            if (grant[j]) begin
                g_idx = pw'(j);
            end
        end
    end

    base_mux #(.width(width), .ways(ways)) u_mux (
        .sel (grant),
        .d   (i_d),
        .q   (sel_d)
    );

    always_comb begin
        state_d    = state_q;
        lock_way_d = lock_way_q;
        if (accept) begin
            case (state_q)
                LOCK_IDLE: begin
                    if (!sel_e) begin
                        state_d    = LOCK_HELD;
                        lock_way_d = g_idx;
                    end
                end
                LOCK_HELD: begin
                    if (sel_e) begin
                        state_d = LOCK_IDLE;
                    end
                end
                default: state_d = LOCK_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q    <= LOCK_IDLE;
            lock_way_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            lock_way_q <= lock_way_d;
            if (accept && sel_e) begin
                ptr_q <= (g_idx == pw'(ways - 1)) ? '0 : g_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_v   <= 1'b0;
            o_e   <= 1'b0;
            o_d   <= '0;
            o_sel <= '0;
        end else if (en) begin
            if (accept) begin
                o_v   <= 1'b1;
                o_e   <= sel_e;
                o_d   <= sel_d;
                o_sel <= grant;
            end else begin
                o_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_base_rrmux.sv
// Self-checking bench for base_rrmux: directed scenarios plus random traffic against a queue-free reference model.
module tb_base_rrmux;

    localparam int WIDTH = 8;
    localparam int WAYS  = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [WAYS-1:0]       i_v, i_r, i_e, o_sel;
    logic [WIDTH*WAYS-1:0] i_d;
    logic                  o_v, o_r, o_e;
    logic [WIDTH-1:0]      o_d;

    always #5 clk = ~clk;

    base_rrmux #(.width(WIDTH), .ways(WAYS)) dut (
        .clk   (clk),
        .reset (reset),
        .i_v   (i_v),
        .i_r   (i_r),
        .i_e   (i_e),
        .i_d   (i_d),
        .o_v   (o_v),
        .o_r   (o_r),
        .o_e   (o_e),
        .o_d   (o_d),
        .o_sel (o_sel)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: priority pointer, packet lock and the held output beat.
    int         m_ptr      = 0;
    bit         m_locked   = 1'b0;
    int         m_lock_way = 0;
    logic       m_ov       = 1'b0;
    logic       m_oe       = 1'b0;
    logic [7:0] m_od       = '0;
    logic [3:0] m_osel     = '0;
    logic [3:0] exp_ir, obs_ir;

    function automatic int pick(input logic [WAYS-1:0] v);
        if (m_locked) return v[m_lock_way] ? m_lock_way : -1;
        for (int k = 0; k < WAYS; k++) begin
            if (v[(m_ptr + k) % WAYS]) return (m_ptr + k) % WAYS;
        end
        return -1;
    endfunction

    // Drive one cycle, record observed/expected ready, advance the model at the edge.
    task automatic step(input bit rst, input logic [3:0] v, input logic [3:0] e,
                        input logic [31:0] d, input bit ready);
        int g;
        bit en;
        reset = rst;
        i_v   = v;
        i_e   = e;
        i_d   = d;
        o_r   = ready;
        #1;
        en     = !m_ov || ready;
        g      = pick(v);
        exp_ir = (!rst && en && g >= 0) ? 4'(1 << g) : 4'b0000;
        obs_ir = i_r;
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_locked = 1'b0; m_lock_way = 0;
            m_ov = 1'b0; m_oe = 1'b0; m_od = '0; m_osel = '0;
        end else if (en) begin
            if (g >= 0) begin
                m_ov   = 1'b1;
                m_oe   = e[g];
                m_od   = d[g*8 +: 8];
                m_osel = 4'(1 << g);
                if (!m_locked && !e[g]) begin
                    m_locked   = 1'b1;
                    m_lock_way = g;
                end else if (m_locked && e[g]) begin
                    m_locked = 1'b0;
                end
                if (e[g]) m_ptr = (g + 1) % WAYS;
            end else begin
                m_ov = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 4'h0, 4'h0, 32'h0, 1'b1);
        step(1'b1, 4'h0, 4'h0, 32'h0, 1'b1);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 4'hF, 4'hF, $urandom(), 1'b1);
            checks++;
            if (obs_ir !== 4'b0000 || o_v !== 1'b0 || o_sel !== 4'b0000) begin
                errors++;
                $display("FAIL reset state: i_r=%b o_v=%b o_sel=%b, want 0000/0/0000", obs_ir, o_v, o_sel);
            end
        end
        step(1'b0, 4'hF, 4'hF, $urandom(), 1'b1);
        checks++;
        if (o_v !== 1'b1 || o_sel !== 4'b0001 || obs_ir !== 4'b0001) begin
            errors++;
            $display("FAIL reset first grant: o_v=%b o_sel=%b i_r=%b, want 1/0001/0001", o_v, o_sel, obs_ir);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 4'hF, 4'hF, $urandom(), 1'b1);
            checks++;
            if (o_v !== 1'b1 || o_sel !== seq[c]) begin
                errors++;
                $display("FAIL round robin beat %0d: o_v=%b o_sel=%b, want 1/%b", c, o_v, o_sel, seq[c]);
            end
            checks++;
            if ({o_v, o_e, o_d, o_sel} !== {m_ov, m_oe, m_od, m_osel}) begin
                errors++;
                $display("FAIL round robin model: got %h want %h", {o_v, o_e, o_d, o_sel}, {m_ov, m_oe, m_od, m_osel});
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        step(1'b0, 4'b0001, 4'b0001, 32'h0000_00A5, 1'b1);
        checks++;
        if (o_v !== 1'b1 || o_d !== 8'hA5) begin
            errors++;
            $display("FAIL backpressure load: o_v=%b o_d=%h, want 1/a5", o_v, o_d);
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 4'hF, 4'hF, $urandom(), 1'b0);
            checks++;
            if (o_v !== 1'b1 || o_d !== 8'hA5 || obs_ir !== 4'b0000) begin
                errors++;
                $display("FAIL backpressure hold %0d: o_v=%b o_d=%h i_r=%b, want 1/a5/0000", c, o_v, o_d, obs_ir);
            end
        end
        step(1'b0, 4'hF, 4'hF, 32'h5A4B_3C2D, 1'b1);
        checks++;
        if (o_v !== 1'b1 || o_d !== 8'h3C || o_sel !== 4'b0010 || obs_ir !== 4'b0010) begin
            errors++;
            $display("FAIL backpressure release: o_d=%h o_sel=%b i_r=%b, want 3c/0010/0010", o_d, o_sel, obs_ir);
        end
    endtask

    task automatic test_packet_lock();
        logic [3:0] vs [3];
        logic [3:0] es [3];
        vs = '{4'b0010, 4'b0111, 4'b0111};
        es = '{4'b0000, 4'b0000, 4'b0010};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            step(1'b0, vs[c], es[c], $urandom(), 1'b1);
            checks++;
            if (o_v !== 1'b1 || o_sel !== 4'b0010 || o_e !== es[c][1]) begin
                errors++;
                $display("FAIL packet lock beat %0d: o_v=%b o_sel=%b o_e=%b, want 1/0010/%b", c, o_v, o_sel, o_e, es[c][1]);
            end
        end
        step(1'b0, 4'b0101, 4'b0101, $urandom(), 1'b1);
        checks++;
        if (o_sel !== 4'b0100) begin
            errors++;
            $display("FAIL packet lock next grant: o_sel=%b, want 0100", o_sel);
        end
    endtask

    task automatic test_locked_bubble();
        do_reset();
        step(1'b0, 4'b0010, 4'b0000, $urandom(), 1'b1);
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 4'b1000, 4'b1000, $urandom(), 1'b1);
            checks++;
            if (o_v !== 1'b0 || obs_ir !== 4'b0000) begin
                errors++;
                $display("FAIL locked bubble %0d: o_v=%b i_r=%b, want 0/0000", c, o_v, obs_ir);
            end
        end
        step(1'b0, 4'b1010, 4'b1010, $urandom(), 1'b1);
        checks++;
        if (o_v !== 1'b1 || o_sel !== 4'b0010 || o_e !== 1'b1) begin
            errors++;
            $display("FAIL locked resume: o_v=%b o_sel=%b o_e=%b, want 1/0010/1", o_v, o_sel, o_e);
        end
        step(1'b0, 4'b1000, 4'b1000, $urandom(), 1'b1);
        checks++;
        if (o_v !== 1'b1 || o_sel !== 4'b1000) begin
            errors++;
            $display("FAIL locked after end: o_v=%b o_sel=%b, want 1/1000", o_v, o_sel);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        step(1'b0, 4'b0100, 4'b0000, $urandom(), 1'b1);
        step(1'b1, 4'b0101, 4'b0000, $urandom(), 1'b1);
        checks++;
        if (o_v !== 1'b0 || obs_ir !== 4'b0000) begin
            errors++;
            $display("FAIL reset mid packet discard: o_v=%b i_r=%b, want 0/0000", o_v, obs_ir);
        end
        step(1'b0, 4'b0101, 4'b0000, $urandom(), 1'b1);
        checks++;
        if (o_v !== 1'b1 || o_sel !== 4'b0001) begin
            errors++;
            $display("FAIL reset mid packet regrant: o_v=%b o_sel=%b, want 1/0001", o_v, o_sel);
        end
    endtask

    task automatic test_random();
        bit rst;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            step(rst, 4'($urandom()), 4'($urandom()), $urandom(), ($urandom_range(0, 3) != 0));
            checks++;
            if (obs_ir !== exp_ir) begin
                errors++;
                $display("FAIL random i_r cycle %0d: got %b want %b", c, obs_ir, exp_ir);
            end
            checks++;
            if ({o_v, o_e, o_d, o_sel} !== {m_ov, m_oe, m_od, m_osel}) begin
                errors++;
                $display("FAIL random out cycle %0d: got %h want %h", c, {o_v, o_e, o_d, o_sel}, {m_ov, m_oe, m_od, m_osel});
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        i_v   = '0;
        i_e   = '0;
        i_d   = '0;
        o_r   = 1'b1;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_packet_lock();
        test_locked_bubble();
        test_reset_mid_packet();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
